// File: rtl/vga_fetch.sv
// vga_fetch: one 36-bit frame-buffer word per vga_flag; done_vga 3 cycles after grant; mem_req held until granted.
// A second queued request overruns into sticky underrun. Define VGA_FETCH_TESTPAT_EN for colour bars with no memory access.
module vga_fetch #(
  parameter int WORDS_PER_FRAME = 153600,
  parameter int ADDR_W          = 19,
  parameter int BASE0           = 0,
  parameter int BASE1           = 262144,
  parameter int READ_LAT        = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vga_flag,
  input  logic              frame_flag,
  input  logic              buffer_sel,
  input  logic              mem_grant,
  input  logic [35:0]       mem_read_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [35:0]       vga_pixel,
  output logic              done_vga,
  output logic              underrun
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int LAT_W = $clog2(READ_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_OFS = ADDR_W'(WORDS_PER_FRAME - 1);
  localparam logic [ADDR_W-1:0] BASE0_A  = ADDR_W'(BASE0);
  localparam logic [ADDR_W-1:0] BASE1_A  = ADDR_W'(BASE1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(READ_LAT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [35:0]         pix_q, pix_d;
  logic                pend_q, pend_d;
  logic                clr_q, clr_d;
  logic                sel_q, sel_d;
  logic                req_q, req_d;
  logic                done_q, done_d;
  logic                und_q, und_d;

`ifdef VGA_FETCH_TESTPAT_EN
  // col/bar track (offset mod 320) / 40; frame size is a multiple of 320 so they wrap with offset.
  logic [5:0] col_q, col_d;
  logic [2:0] bar_q, bar_d;
  logic [17:0] bar_pix;

  always_comb begin
    bar_pix = 18'h0;
    case (bar_q)
      3'd0: bar_pix = {6'd63, 6'd32, 6'd32};
      3'd1: bar_pix = {6'd56, 6'd34, 6'd4};
      3'd2: bar_pix = {6'd45, 6'd4,  6'd42};
      3'd3: bar_pix = {6'd37, 6'd6,  6'd14};
      3'd4: bar_pix = {6'd26, 6'd58, 6'd50};
      3'd5: bar_pix = {6'd18, 6'd60, 6'd22};
      3'd6: bar_pix = {6'd7,  6'd30, 6'd60};
      default: bar_pix = {6'd0, 6'd32, 6'd32};
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    addr_d   = addr_q;
    lat_d    = lat_q;
    pix_d    = pix_q;
    pend_d   = pend_q;
    clr_d    = clr_q;
    sel_d    = sel_q;
    req_d    = req_q;
    done_d   = 1'b0;
    und_d    = und_q;
`ifdef VGA_FETCH_TESTPAT_EN
    col_d    = col_q;
    bar_d    = bar_q;
`endif

    if (frame_flag) sel_d = buffer_sel;
    if (state_q != IDLE) begin
      if (frame_flag) clr_d = 1'b1;
      if (vga_flag) begin
        if (pend_q) und_d  = 1'b1;
        else        pend_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (frame_flag) begin
          offset_d = '0;
`ifdef VGA_FETCH_TESTPAT_EN
          col_d = '0;
          bar_d = '0;
`endif
        end
        if (vga_flag || pend_q) begin
          state_d = REQ;
          pend_d  = vga_flag && pend_q;
          addr_d  = (sel_d ? BASE1_A : BASE0_A) + (frame_flag ? '0 : offset_q);
`ifndef VGA_FETCH_TESTPAT_EN
          req_d   = 1'b1;
`endif
        end
      end
      REQ: begin
`ifdef VGA_FETCH_TESTPAT_EN
        pix_d   = {bar_pix, bar_pix};
        done_d  = 1'b1;
        state_d = DONE;
`else
        if (mem_grant) begin
          req_d   = 1'b0;
          lat_d   = '0;
          state_d = WAIT;
        end
`endif
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          pix_d   = mem_read_data;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        // A frame restart seen during this fetch takes effect only now, after the old address was used.
        if (clr_q || frame_flag) begin
          offset_d = '0;
          clr_d    = 1'b0;
`ifdef VGA_FETCH_TESTPAT_EN
          col_d = '0;
          bar_d = '0;
`endif
        end else begin
          offset_d = (offset_q == LAST_OFS) ? '0 : offset_q + ADDR_W'(1);
`ifdef VGA_FETCH_TESTPAT_EN
          if (col_q == 6'd39) begin
            col_d = '0;
            bar_d = bar_q + 3'd1;
          end else begin
            col_d = col_q + 6'd1;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      offset_q <= '0;
      addr_q   <= '0;
      lat_q    <= '0;
      pix_q    <= '0;
      pend_q   <= 1'b0;
      clr_q    <= 1'b0;
      sel_q    <= 1'b0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      und_q    <= 1'b0;
`ifdef VGA_FETCH_TESTPAT_EN
      col_q    <= '0;
      bar_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      addr_q   <= addr_d;
      lat_q    <= lat_d;
      pix_q    <= pix_d;
      pend_q   <= pend_d;
      clr_q    <= clr_d;
      sel_q    <= sel_d;
      req_q    <= req_d;
      done_q   <= done_d;
      und_q    <= und_d;
`ifdef VGA_FETCH_TESTPAT_EN
      col_q    <= col_d;
      bar_q    <= bar_d;
`endif
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_we    = 1'b0;
  assign vga_pixel = pix_q;
  assign done_vga  = done_q;
  assign underrun  = und_q;

endmodule

// File: doc/vga_fetch.md
# vga_fetch

Memory-side read engine feeding the VGA writer. Each `vga_flag` request fetches one 36-bit word (two packed 18-bit YCrCb pixels) from the active ZBT frame buffer through the memory arbiter. It returns the word on `vga_pixel` with a `done_vga` pulse. It walks the frame linearly, wraps at end of frame, and swaps frame buffers on `frame_flag`.

## Interface

Parameters:
- `WORDS_PER_FRAME`, 153600: words per frame (640x480 / 2 pixels per word).
- `ADDR_W`, 19: memory address width.
- `BASE0`, 0: word address of frame buffer 0.
- `BASE1`, 262144: word address of frame buffer 1.
- `READ_LAT`, 2: cycles from granted read to valid `mem_read_data`.

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `vga_flag`, in, 1: one-cycle fetch request from the VGA writer.
- `frame_flag`, in, 1: one-cycle start-of-frame pulse.
- `buffer_sel`, in, 1: frame buffer to display; latched on `frame_flag`.
- `mem_grant`, in, 1: arbiter grant for the current `mem_req`.
- `mem_read_data`, in, 36: memory read data.
- `mem_req`, out, 1: read request; held until granted.
- `mem_addr`, out, ADDR_W: read address; stable while `mem_req` is high.
- `mem_we`, out, 1: always 0 (read-only client).
- `vga_pixel`, out, 36: last fetched word; [35:18] = odd pixel, [17:0] = even pixel.
- `done_vga`, out, 1: one-cycle pulse when `vga_pixel` is updated.
- `underrun`, out, 1: sticky request-overrun error; cleared only by reset.

## Operation

- FSM states:
  - IDLE: on a request (new `vga_flag` or pending bit) -> REQ.
  - REQ: assert `mem_req` with `mem_addr` = base + offset. On `mem_req & mem_grant` -> WAIT and clear the latency counter.
  - WAIT: count `READ_LAT` cycles, then capture `mem_read_data` -> DONE.
  - DONE: drive captured word on `vga_pixel`, pulse `done_vga`, advance offset -> IDLE.
- Offset arithmetic:
  - Counter width is ADDR_W bits.
  - Offset increments by 1 per completed fetch.
  - Offset `WORDS_PER_FRAME-1` wraps to 0.
- Base selection: base = BASE1 when latched `buffer_sel`=1, else BASE0. The latch resets to 0.
- Request queueing:
  - A `vga_flag` arriving outside IDLE sets a single pending bit.
  - A `vga_flag` arriving while the pending bit is already set sets `underrun`; that request is dropped.
- `frame_flag` handling:
  - Clears offset to 0 and latches `buffer_sel`.
  - If a fetch is in flight, that fetch completes with its old address. The clear applies afterwards, so the DONE-state increment is suppressed and the next fetch reads offset 0.
  - `frame_flag` and `vga_flag` in the same cycle while in IDLE: the clear wins and the fetch reads base + 0 of the newly selected buffer.
- Reset mid-operation: the FSM returns to IDLE immediately. Pending bit and offset clear. A grant arriving afterwards is ignored.

## Timing

- Reset values: `mem_req`=0, `mem_addr`=0, `mem_we`=0, `vga_pixel`=0, `done_vga`=0, `underrun`=0. FSM=IDLE, offset=0, pending=0.
- All outputs are registered.
- Latency with `vga_flag` sampled at cycle 0:
  - `mem_req` rises at cycle 1.
  - If granted at cycle G, data is captured at G+READ_LAT.
  - `done_vga` and new `vga_pixel` appear at G+READ_LAT+1.
  - With grant tied high: `done_vga` at cycle 4.
- `mem_req` deasserts the cycle after the grant.
- `mem_addr` holds its value until the next REQ.
- `vga_pixel` holds between `done_vga` pulses.
- Throughput requirement: the total round trip must be shorter than the `vga_flag` period (two pixel clocks). Otherwise `underrun` sets.

## Configuration

- `VGA_FETCH_TESTPAT_EN` defined:
  - No memory access: `mem_req` stays 0.
  - The FSM goes REQ->DONE in one cycle.
  - `vga_pixel` = 8 vertical colour bars in YCrCb, selected by offset mod 320 divided by 40, same value in both halves.
  - `done_vga` timing: cycle 2 after `vga_flag`.
- Undefined: normal memory fetch as above.

## Test plan

- Grant tied high, `READ_LAT`=2, `vga_flag` at cycle 0 -> `mem_req`=1 at cycle 1 with `mem_addr`=0; `done_vga` at cycle 4 with `vga_pixel`=`mem_read_data` from cycle 3.
- Grant delayed 5 cycles -> `mem_req` and `mem_addr` held steady for 5 cycles; `done_vga` exactly 3 cycles after grant; `underrun` stays 0 if the next `vga_flag` comes after that.
- 153600 requests followed by one more -> last `mem_addr` = 153599; next `mem_addr` = 0 (wrap).
- `buffer_sel`=1 plus `frame_flag` during WAIT of the fetch at offset 100 -> that fetch completes at address 100; next `mem_addr` = 262144.
- Three `vga_flag` pulses while grant is held low -> one serviced, one pending, `underrun`=1 and stays 1 until reset.
- Reset asserted during WAIT -> all outputs 0 the same cycle; a subsequent `mem_grant` produces no `done_vga`; first fetch after reset reads address 0.
